// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: packs up to NumRet retirements per cycle into a
// FIFO, with continuous or PC-triggered capture and all-or-nothing overflow drops.
module ibex_rvfi_trace_buffer #(
  parameter int unsigned NumRet   = 1,
  parameter int unsigned Depth    = 16,
  parameter int unsigned PostTrig = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 mode_i,
  input  logic [31:0]          trig_pc_i,
  input  logic [NumRet-1:0]    rvfi_valid,
  input  logic [32*NumRet-1:0] rvfi_pc_rdata,
  input  logic [32*NumRet-1:0] rvfi_insn,
  input  logic [32*NumRet-1:0] rvfi_rd_wdata,
  input  logic [5*NumRet-1:0]  rvfi_rd_addr,
  input  logic [NumRet-1:0]    rvfi_trap,
  input  logic [NumRet-1:0]    rvfi_intr,
  output logic                 trace_valid_o,
  input  logic                 trace_ready_i,
  output logic [103:0]         trace_data_o,
  output logic [15:0]          drop_cnt_o,
  output logic [1:0]           state_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = $clog2(NumRet + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [KW-1:0] popcnt(input logic [NumRet-1:0] v);
    logic [KW-1:0] c;
    c = '0;
    for (int i = 0; i < NumRet; i++) c = c + KW'(v[i]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [KW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_e        state;
  logic          trig_mode;
  logic [7:0]    post_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] wptr, rptr;
  logic          ovf_pending;
  logic [103:0]  mem [Depth];

  logic [KW-1:0] k;
  logic [CW-1:0] free;
  logic          trig_hit, wr_cycle, accept, drop, pop;
  logic [8:0]    post_sum;
  logic          post_done;
  logic [AW-1:0] offs;
  logic          first;
  logic [103:0]  rec  [NumRet];
  logic [AW-1:0] slot [NumRet];

  // Per-channel records and slots: valid channels pack densely from wptr,
  // and only the first one written carries a pending overflow marker.
  always_comb begin
    offs     = '0;
    first    = 1'b1;
    trig_hit = 1'b0;
    for (int i = 0; i < NumRet; i++) begin
      if (rvfi_valid[i] && (rvfi_pc_rdata[32*i +: 32] == trig_pc_i)) trig_hit = 1'b1;
      rec[i]  = {ovf_pending & first, rvfi_trap[i], rvfi_intr[i], rvfi_rd_addr[5*i +: 5],
                 rvfi_insn[32*i +: 32], rvfi_pc_rdata[32*i +: 32], rvfi_rd_wdata[32*i +: 32]};
      slot[i] = wptr + offs;
      if (rvfi_valid[i]) begin
        offs  = offs + AW'(1);
        first = 1'b0;
      end
    end
  end

  assign k         = popcnt(rvfi_valid);
  assign free      = CW'(Depth) - count;
  assign wr_cycle  = enable_i && ((state == CAPTURE) || ((state == ARMED) && trig_hit));
  assign accept    = wr_cycle && (k != '0) && (CW'(k) <= free);
  assign drop      = wr_cycle && (k != '0) && !(CW'(k) <= free);
  assign pop       = trace_valid_o && trace_ready_i;
  assign post_sum  = {1'b0, post_cnt} + 9'(accept ? k : '0);
  assign post_done = post_sum >= 9'(PostTrig);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      trig_mode   <= 1'b0;
      post_cnt    <= '0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      drop_cnt_o  <= '0;
      ovf_pending <= 1'b0;
    end else begin
      count <= count + (accept ? CW'(k) : '0) - CW'(pop);
      if (accept) wptr <= wptr + AW'(k);
      if (pop) rptr <= rptr + AW'(1);
      if (drop) begin
        drop_cnt_o  <= sat_add16(drop_cnt_o, k);
        ovf_pending <= 1'b1;
      end else if (accept) begin
        ovf_pending <= 1'b0;
      end
      if (!enable_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            trig_mode <= mode_i;
            post_cnt  <= '0;
            state     <= mode_i ? ARMED : CAPTURE;
          end
          ARMED: begin
            if (trig_hit) begin
              post_cnt <= post_sum[7:0];
              state    <= post_done ? DONE : CAPTURE;
            end
          end
          CAPTURE: begin
            if (trig_mode) begin
              post_cnt <= post_sum[7:0];
              if (post_done) state <= DONE;
            end
          end
          default: state <= DONE;
        endcase
      end
    end
  end

  // Record storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int i = 0; i < NumRet; i++) begin
        if (rvfi_valid[i]) mem[slot[i]] <= rec[i];
      end
    end
  end

  assign trace_valid_o = (count != '0);
  assign trace_data_o  = mem[rptr];
  assign state_o       = state;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Randomized and directed scoreboard bench for ibex_rvfi_trace_buffer.
module tb_ibex_rvfi_trace_buffer;
  localparam int NR  = 2;
  localparam int DEP = 4;
  localparam int PT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, mode, ready;
  logic [31:0]   trig;
  logic [NR-1:0] valid, trap, intr;
  logic [32*NR-1:0] pc, insn, wd;
  logic [5*NR-1:0]  rda;
  logic          tv;
  logic [103:0]  td;
  logic [15:0]   dc;
  logic [1:0]    st;

  ibex_rvfi_trace_buffer #(.NumRet(NR), .Depth(DEP), .PostTrig(PT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .mode_i(mode), .trig_pc_i(trig),
    .rvfi_valid(valid), .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_rd_wdata(wd),
    .rvfi_rd_addr(rda), .rvfi_trap(trap), .rvfi_intr(intr),
    .trace_valid_o(tv), .trace_ready_i(ready), .trace_data_o(td),
    .drop_cnt_o(dc), .state_o(st)
  );

  // Reference model state
  int m_state, m_occ, m_drop, m_post;
  bit m_ovf, m_tmode;
  logic [103:0] exp_q[$];
  logic [103:0] got_q[$];
  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [103:0] mkrec(input bit ovf, input int i);
    return {ovf, trap[i], intr[i], rda[i*5 +: 5], insn[i*32 +: 32], pc[i*32 +: 32], wd[i*32 +: 32]};
  endfunction

  task automatic model_step();
    int k, hit, pop, wr, acc, drp, first;
    if (rst) begin
      m_state = 0; m_occ = 0; m_drop = 0; m_ovf = 0; m_post = 0; m_tmode = 0;
      exp_q.delete();
      return;
    end
    k = 0; hit = 0;
    for (int i = 0; i < NR; i++)
      if (valid[i]) begin
        k++;
        if (pc[i*32 +: 32] == trig) hit = 1;
      end
    pop = (m_occ > 0 && ready) ? 1 : 0;
    wr  = (en && (m_state == 2 || (m_state == 1 && hit != 0))) ? 1 : 0;
    acc = (wr != 0 && k > 0 && k <= DEP - m_occ) ? 1 : 0;
    drp = (wr != 0 && k > 0 && acc == 0) ? 1 : 0;
    if (acc != 0) begin
      first = 1;
      for (int i = 0; i < NR; i++)
        if (valid[i]) begin
          exp_q.push_back(mkrec(m_ovf && first != 0, i));
          first = 0;
        end
      m_ovf = 0;
    end
    if (drp != 0) begin
      m_drop = (m_drop + k > 65535) ? 65535 : m_drop + k;
      m_ovf = 1;
    end
    m_occ = m_occ + (acc != 0 ? k : 0) - pop;
    if (!en) m_state = 0;
    else case (m_state)
      0: begin m_tmode = mode; m_post = 0; m_state = mode ? 1 : 2; end
      1: if (hit != 0) begin
           m_post += (acc != 0) ? k : 0;
           m_state = (m_post >= PT) ? 3 : 2;
         end
      2: if (m_tmode) begin
           m_post += (acc != 0) ? k : 0;
           if (m_post >= PT) m_state = 3;
         end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int i, input bit v, input logic [31:0] p);
    valid[i] = v;
    pc[i*32 +: 32] = p;
    insn[i*32 +: 32] = $urandom;
    wd[i*32 +: 32] = $urandom;
    rda[i*5 +: 5] = 5'($urandom);
    trap[i] = 1'($urandom);
    intr[i] = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("trace_valid", 104'(tv), 104'(m_occ != 0));
      chk("state", 104'(st), 104'(m_state));
      chk("drop_cnt", 104'(dc), 104'(m_drop));
      if (tv && ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_record actual=%0h required=none", td);
        end else begin
          chk("record", td, exp_q.pop_front());
        end
        got_q.push_back(td);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [103:0] r;
    rst = 1; en = 0; mode = 0; ready = 0; trig = '0;
    valid = '0; trap = '0; intr = '0; pc = '0; insn = '0; wd = '0; rda = '0;
    tick();
    tick();
    mon_en = 1;
    rst = 0;
    chk("reset_valid", 104'(tv), 0);
    chk("reset_state", 104'(st), 0);
    chk("reset_drop", 104'(dc), 0);

    // Two channels in one cycle come out in channel order
    en = 1; mode = 0; ready = 1;
    tick();
    n0 = got_q.size();
    set_ch(0, 1, 32'h100); set_ch(1, 1, 32'h104);
    tick();
    valid = '0;
    repeat (3) tick();
    chk("t1_count", 104'(got_q.size() - n0), 2);
    r = got_q[n0];     chk("t1_pc0", 104'(r[63:32]), 104'h100); chk("t1_ovf0", 104'(r[103]), 0);
    r = got_q[n0 + 1]; chk("t1_pc1", 104'(r[63:32]), 104'h104);

    // Overflow: third pair dropped, next accepted record flagged
    ready = 0;
    for (int c = 0; c < 3; c++) begin
      set_ch(0, 1, 32'h180 + 8 * c); set_ch(1, 1, 32'h184 + 8 * c);
      tick();
    end
    valid = '0;
    tick();
    chk("t2_drop_cnt", 104'(dc), 2);
    ready = 1;
    repeat (5) tick();
    set_ch(0, 1, 32'h300);
    tick();
    valid = '0;
    repeat (3) tick();
    r = got_q[got_q.size() - 1];
    chk("t2_ovf_pc", 104'(r[63:32]), 104'h300);
    chk("t2_ovf_flag", 104'(r[103]), 1);

    // Full FIFO with a pop in the same cycle still drops
    n0 = got_q.size();
    ready = 0;
    repeat (2) begin
      set_ch(0, 1, $urandom); set_ch(1, 1, $urandom);
      tick();
    end
    ready = 1;
    set_ch(1, 0, 32'h0); set_ch(0, 1, 32'h444);
    tick();
    chk("t3_drop_inc", 104'(dc), 3);
    chk("t3_valid_after", 104'(tv), 1);
    valid = '0;
    repeat (5) tick();
    chk("t3_pops", 104'(got_q.size() - n0), 4);

    // Triggered capture window
    en = 0;
    tick();
    en = 1; mode = 1; trig = 32'h200; ready = 1;
    tick();
    chk("t4_armed", 104'(st), 1);
    n0 = got_q.size();
    for (int p = 32'h1F8; p <= 32'h210; p += 4) begin
      set_ch(0, 1, 32'(p)); set_ch(1, 0, 32'h0);
      tick();
    end
    valid = '0;
    repeat (3) tick();
    chk("t4_state_done", 104'(st), 3);
    chk("t4_count", 104'(got_q.size() - n0), 3);
    for (int j = 0; j < 3; j++) begin
      r = got_q[n0 + j];
      chk("t4_pc", 104'(r[63:32]), 104'(32'h200 + 4 * j));
    end

    // Reset with records buffered
    en = 0; tick();
    en = 1; mode = 0; tick();
    ready = 0;
    set_ch(0, 1, 32'h500); set_ch(1, 1, 32'h504); tick();
    set_ch(0, 1, 32'h508); set_ch(1, 0, 32'h0); tick();
    valid = '0;
    chk("t5_pre_valid", 104'(tv), 1);
    rst = 1;
    set_ch(0, 1, 32'h50C);
    tick();
    rst = 0; valid = '0;
    chk("t5_valid", 104'(tv), 0);
    chk("t5_state", 104'(st), 0);
    chk("t5_drop", 104'(dc), 0);
    repeat (3) tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(29) == 0) begin
        en = ~en;
        mode = 1'($urandom);
      end
      trig = 32'h200 + 4 * $urandom_range(7);
      for (int i = 0; i < NR; i++) set_ch(i, 1'($urandom), 32'h200 + 4 * $urandom_range(7));
      ready = ($urandom_range(3) != 0);
      tick();
    end
    rst = 0; en = 0; valid = '0; ready = 1;
    repeat (10) tick();
    chk("rand_drained", 104'(exp_q.size()), 0);

    // Drop counter saturation
    rst = 1; tick(); rst = 0;
    en = 1; mode = 0; ready = 0;
    tick();
    for (int n = 0; n < 32770; n++) begin
      set_ch(0, 1, 32'h600); set_ch(1, 1, 32'h604);
      tick();
    end
    chk("t7_sat", 104'(dc), 104'hFFFF);
    set_ch(1, 0, 32'h0);
    tick();
    valid = '0;
    chk("t7_sat_hold", 104'(dc), 104'hFFFF);
    en = 0; ready = 1;
    repeat (8) tick();
    chk("t7_drained", 104'(exp_q.size()), 0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
